// File: rtl/unidade_controle_rodadas.sv
// Moore controller for the memory-sequence game: single-pass or progressive-round play,
// with a per-play timeout that restarts on every entry into espera_jogada.
module unidade_controle_rodadas #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CICLOS)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       modo,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT_W < 1) ? 1 : TIMEOUT_W;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FINAL_TIMEOUT  = 4'hD,
    FINAL_ACERTOU  = 4'hE,
    FINAL_ERROU    = 4'hF
  } estado_t;

  estado_t       estado, prox_estado;
  logic [TW-1:0] timer;
  logic          modo_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      timer    <= '0;
      modo_reg <= 1'b0;
    end else begin
      estado <= prox_estado;
      if (estado == PREPARACAO) modo_reg <= modo;
      // Counts only while waiting for a play; saturates so it can never wrap back.
      if (estado == ESPERA_JOGADA) begin
        if (timer != TIMER_MAX) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
    end
  end

  always_comb begin
    prox_estado = INICIAL;
    case (estado)
      INICIAL:        prox_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     prox_estado = INICIA_RODADA;
      INICIA_RODADA:  prox_estado = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada)                  prox_estado = REGISTRA;
        else if (timer == TIMER_MAX) prox_estado = FINAL_TIMEOUT;
        else                         prox_estado = ESPERA_JOGADA;
      end
      REGISTRA:       prox_estado = COMPARA;
      COMPARA: begin
        if (!igual)                    prox_estado = FINAL_ERROU;
        else if (!modo_reg)            prox_estado = fimE ? FINAL_ACERTOU : PROXIMO;
        else if (enderecoIgualLimite)  prox_estado = fimL ? FINAL_ACERTOU : PROXIMA_RODADA;
        else                           prox_estado = PROXIMO;
      end
      PROXIMO:        prox_estado = ESPERA_JOGADA;
      PROXIMA_RODADA: prox_estado = INICIA_RODADA;
      FINAL_TIMEOUT, FINAL_ACERTOU, FINAL_ERROU:
                      prox_estado = iniciar ? PREPARACAO : estado;
      default:        prox_estado = INICIAL;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    case (estado)
      INICIAL, PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      INICIA_RODADA:  zeraE     = 1'b1;
      REGISTRA:       registraR = 1'b1;
      PROXIMO:        contaE    = 1'b1;
      PROXIMA_RODADA: contaL    = 1'b1;
      FINAL_TIMEOUT: begin
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      FINAL_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FINAL_ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: game-level reference model compared every cycle,
// directed game scenarios with literal expectations, then randomized play.
module tb_unidade_controle_rodadas;
  localparam int T = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 0, modo = 0, jogada = 0, igual = 0, fimE = 0, enderecoIgualLimite = 0, fimL = 0;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  unidade_controle_rodadas #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .jogada(jogada),
    .igual(igual), .fimE(fimE), .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL), .zeraR(zeraR),
    .registraR(registraR), .acertou(acertou), .errou(errou), .timeout(timeout),
    .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Game-level reference: phase code, play index within the wait window, latched mode.
  int m_st = 0;
  int m_k = 0;
  bit m_modo = 0;

  always @(posedge clock or negedge reset) begin
    int ns;
    if (!reset) begin
      m_st = 0; m_k = 0; m_modo = 0;
    end else begin
      ns = 0;
      case (m_st)
        0: ns = iniciar ? 1 : 0;
        1: begin m_modo = modo; ns = 2; end
        2: ns = 3;
        3: ns = jogada ? 4 : (m_k == T) ? 13 : 3;
        4: ns = 5;
        5: begin
          if (!igual) ns = 15;
          else if (!m_modo) ns = fimE ? 14 : 6;
          else if (enderecoIgualLimite) ns = fimL ? 14 : 7;
          else ns = 6;
        end
        6: ns = 3;
        7: ns = 2;
        13, 14, 15: ns = iniciar ? 1 : m_st;
        default: ns = 0;
      endcase
      m_k = (ns == 3) ? ((m_st == 3) ? m_k + 1 : 1) : 0;
      m_st = ns;
    end
  end

  function automatic logic [13:0] expected(int s);
    logic [13:0] v;
    v[13] = (s == 0 || s == 1 || s == 2);     // zeraE
    v[12] = (s == 6);                          // contaE
    v[11] = (s == 0 || s == 1);                // zeraL
    v[10] = (s == 7);                          // contaL
    v[9]  = (s == 0 || s == 1);                // zeraR
    v[8]  = (s == 4);                          // registraR
    v[7]  = (s == 14);
    v[6]  = (s == 15);
    v[5]  = (s == 13);
    v[4]  = (s >= 13);
    v[3:0] = 4'(s);
    return v;
  endfunction

  wire [13:0] dut_vec = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                         acertou, errou, timeout, pronto, db_estado};

  int n_contaE = 0, n_contaL = 0, n_inicia = 0;

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      logic [13:0] e;
      e = expected(m_st);
      total++;
      if (dut_vec !== e) begin
        bad++;
        $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, dut_vec, e);
      end
    end
    if (contaE) n_contaE++;
    if (contaL) n_contaL++;
    if (db_estado == 4'h2) n_inicia++;
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic wait_state(input int code, input string name);
    int n;
    n = 0;
    while (db_estado !== 4'(code) && n < 60) begin
      cyc();
      n++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL wait_%s got=%0h exp=%0h", name, db_estado, code);
    end
  endtask

  task automatic play(input bit ig, input bit fe, input bit eil, input bit fl);
    wait_state(3, "espera");
    jogada = 1; cyc();
    jogada = 0; cyc();
    igual = ig; fimE = fe; enderecoIgualLimite = eil; fimL = fl;
    cyc();
    igual = 0; fimE = 0; enderecoIgualLimite = 0; fimL = 0;
  endtask

  task automatic start(input bit m);
    modo = m; iniciar = 1; cyc();
    iniciar = 0; cyc();
    modo = ~m;   // mode is latched in preparacao; later changes must not matter
  endtask

  initial begin
    #3 reset = 1'b0;
    chk_en = 1;
    cyc(); cyc();
    check("reset_state", db_estado, 0);
    check("reset_zeraE", zeraE, 1);
    check("reset_pronto", pronto, 0);
    reset = 1'b1;
    cyc();

    // Mode 0: four correct plays, last one at fimE
    n_contaE = 0;
    start(0);
    for (int i = 0; i < 4; i++) play(1, i == 3, 0, 0);
    check("m0_final", db_estado, 'hE);
    check("m0_acertou", acertou, 1);
    check("m0_pronto", pronto, 1);
    check("m0_contaE", n_contaE, 3);

    // Mode 1: limits 0,1,2; fimL at the third limit
    n_contaL = 0; n_inicia = 0;
    start(1);
    play(1, 0, 1, 0);
    play(1, 0, 0, 0); play(1, 0, 1, 0);
    play(1, 0, 0, 0); play(1, 0, 0, 0); play(1, 0, 1, 1);
    check("m1_final", db_estado, 'hE);
    check("m1_contaL", n_contaL, 2);
    check("m1_inicia", n_inicia, 3);

    // Wrong play in round 2
    start(1);
    play(1, 0, 1, 0);
    play(0, 0, 0, 0);
    check("err_state", db_estado, 'hF);
    check("err_errou", errou, 1);
    check("err_acertou", acertou, 0);

    // Timeout: no play for T cycles
    start(0);
    wait_state(3, "espera_to");
    repeat (T - 1) cyc();
    check("to_last_wait", db_estado, 3);
    cyc();
    check("to_state", db_estado, 'hD);
    check("to_flag", timeout, 1);

    // Restart from timeout; a play on the T-th cycle wins
    start(0);
    wait_state(3, "espera_win");
    repeat (T - 1) cyc();
    jogada = 1; cyc(); jogada = 0;
    check("play_wins", db_estado, 4);
    cyc();
    check("compara", db_estado, 5);

    // Async reset in compara
    reset = 1'b0; #1;
    check("midreset_state", db_estado, 0);
    check("midreset_zeraE", zeraE, 1);
    check("midreset_pronto", pronto, 0);
    cyc(); reset = 1'b1;

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset   = ($urandom_range(199) != 0);
      iniciar = ($urandom_range(7) == 0);
      modo    = 1'($urandom);
      jogada  = ($urandom_range(5) == 0);
      igual   = ($urandom_range(3) != 0);
      fimE    = ($urandom_range(3) == 0);
      enderecoIgualLimite = ($urandom_range(2) == 0);
      fimL    = ($urandom_range(2) == 0);
    end
    cyc(); reset = 1'b1;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
